seq_fir_filter: RTL



---
 rtl/fir_pkg.sv | 66 ++++++
 rtl/fir_hist_ram.sv | 46 ++++
 rtl/seq_fir_filter.sv | 131 +++++++++++++
 3 files changed

// File: rtl/fir_pkg.sv
// -----------------------------------------------------------------------------
// fir_pkg
// Shared definitions for the sequential FIR stage:
//   - widths (sample, coefficient, accumulator, history pointer)
//   - FSM state encoding
//   - low-pass coefficient ROM (symmetric, Q1.15, sums to 32768 = unity DC gain)
//   - round_sat(): round-half-up of the Q1.15-scaled accumulator followed by
//     saturation to the signed sample range
// -----------------------------------------------------------------------------
package fir_pkg;

    localparam int DATA_W = 24;
    localparam int TAPS   = 16;
    localparam int COEF_W = 16;
    localparam int PTR_W  = $clog2(TAPS);
    localparam int PROD_W = DATA_W + COEF_W;
    localparam int ACC_W  = DATA_W + COEF_W + PTR_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2,
        HOLD  = 2'd3
    } state_t;

    typedef logic signed [COEF_W-1:0] coef_t;

    // Symmetric low-pass kernel; the two negative side lobes sharpen the
    // transition band. Half-sum is 16384, full sum 32768.
    localparam coef_t COEF [TAPS] = '{
        -16'sd256,  -16'sd512,  16'sd0,     16'sd1024,
         16'sd2048,  16'sd3584, 16'sd4608,  16'sd5888,
         16'sd5888,  16'sd4608, 16'sd3584,  16'sd2048,
         16'sd1024,  16'sd0,   -16'sd512,  -16'sd256
    };

    // Half an LSB of the output scale: 2^(COEF_W-2).
    localparam logic signed [ACC_W-1:0] ROUND_BIAS =
        {{(ACC_W-COEF_W+1){1'b0}}, 1'b1, {(COEF_W-2){1'b0}}};

    // Output range limits expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Arithmetic right shift floors, so adding half an LSB first gives
    // round-half-up. The bias cannot overflow: the accumulator peak magnitude
    // is far below 2^(ACC_W-1).
    function automatic logic [DATA_W-1:0] round_sat(input logic signed [ACC_W-1:0] acc);
        logic signed [ACC_W-1:0] biased;
        logic signed [ACC_W-1:0] shifted;
        logic [DATA_W-1:0]       result;
        biased  = acc + ROUND_BIAS;
        shifted = biased >>> (COEF_W-1);
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end else begin
            result = shifted[DATA_W-1:0];
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_hist_ram.sv
// -----------------------------------------------------------------------------
// fir_hist_ram
// TAPS x DATA_W sample history register file: one synchronous write port,
// one asynchronous read port, asynchronous active-low clear of every entry.
// Ports:
//   clk_i    - clock (rising edge)
//   rst_ni   - asynchronous active-low clear
//   we_i     - write enable
//   waddr_i  - write address
//   wdata_i  - write data
//   raddr_i  - read address
//   rdata_o  - read data (combinational)
// -----------------------------------------------------------------------------
module fir_hist_ram
    import fir_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              we_i,
    input  logic [PTR_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [PTR_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] entry [TAPS];

    // Register-based rather than block RAM: the whole history must clear on
    // reset and the MAC loop needs a same-cycle read.
    for (genvar gi = 0; gi < TAPS; gi++) begin : g_entry
        logic [DATA_W-1:0] entry_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                entry_q <= '0;
            end else if (we_i && (waddr_i == PTR_W'(gi))) begin
                entry_q <= wdata_i;
            end
        end

        assign entry[gi] = entry_q;
    end

    assign rdata_o = entry[raddr_i];

endmodule

// File: rtl/seq_fir_filter.sv
// -----------------------------------------------------------------------------
// seq_fir_filter
// Time-multiplexed FIR low-pass stage: one sample in per valid/ready
// handshake, TAPS single-MAC cycles, one round/saturate cycle, then the
// result is held on a valid/ready output until consumed.
// Ports:
//   CLOCK_50  - clock (rising edge)
//   reset_n   - asynchronous active-low reset
//   in_valid  - input sample present
//   in_data   - input sample, signed DATA_W
//   in_ready  - block can accept a sample (only in IDLE)
//   out_valid - filtered sample available
//   out_data  - filtered sample, signed DATA_W
//   out_ready - downstream accepts the filtered sample
// -----------------------------------------------------------------------------
module seq_fir_filter
    import fir_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    state_t                  state_q, state_d;
    logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0]       out_data_q, out_data_d;

    logic                    accept;
    logic                    last_tap;
    logic [PTR_W-1:0]        rd_addr;
    logic [DATA_W-1:0]       hist_rdata;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0] prod_ext;

    assign accept   = (state_q == IDLE) && in_valid;
    assign last_tap = (k_q == PTR_W'(TAPS-1));

    // wr_ptr has already moved past the newest sample when MAC starts, so the
    // newest entry sits at wr_ptr-1; tap k reaches k samples further back.
    // PTR_W-bit arithmetic gives the modulo-TAPS wrap for free.
    assign rd_addr = wr_ptr_q - PTR_W'(1) - k_q;

    fir_hist_ram u_hist (
        .clk_i   (CLOCK_50),
        .rst_ni  (reset_n),
        .we_i    (accept),
        .waddr_i (wr_ptr_q),
        .wdata_i (in_data),
        .raddr_i (rd_addr),
        .rdata_o (hist_rdata)
    );

    assign prod     = $signed(hist_rdata) * COEF[k_q];
    assign prod_ext = {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};

    // ---------------------------------------------------------------- state register
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------- next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = MAC;
            MAC:     if (last_tap)  state_d = ROUND;
            ROUND:                  state_d = HOLD;
            HOLD:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    // ---------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == HOLD);
        out_data  = out_data_q;
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        k_d        = k_q;
        acc_d      = acc_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    k_d      = '0;
                    acc_d    = '0;
                end
            end
            MAC: begin
                acc_d = acc_q + prod_ext;
                k_d   = k_q + PTR_W'(1);
            end
            ROUND: begin
                out_data_d = round_sat(acc_q);
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
